// File: rtl/cordic_atan_sequencer_if.sv
// Table-read and step-stream signals between the atan ROM, the sequencer and the Z-path engine.
// The master side is the sequencer: it drives the table address and presents steps.
interface cordic_atan_sequencer_if #(
  parameter int W = 32,
  parameter int N = 4
) ();
  logic [N-1:0] lut_addr;
  logic [W-1:0] lut_data;
  logic         step_valid;
  logic         step_ready;
  logic [W-1:0] step_atan;
  logic [N-1:0] step_idx;
  logic         step_last;

  modport master (
    output lut_addr,
    input  lut_data,
    output step_valid,
    input  step_ready,
    output step_atan,
    output step_idx,
    output step_last
  );

  modport slave (
    input  lut_addr,
    output lut_data,
    input  step_valid,
    output step_ready,
    input  step_atan,
    input  step_idx,
    input  step_last
  );
endinterface

// File: rtl/cordic_atan_sequencer.sv
// Walks the atan(2^-i) table and streams one constant per iteration to the CORDIC Z-path.
// Optional run cancellation is compiled in with `define CORDIC_SEQ_ABORT_EN.
module cordic_atan_sequencer #(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int ITER = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  cordic_atan_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [N-1:0] CNT_LAST = N'(ITER - 1);

  state_t         state_q, state_d;
  logic [N-1:0]   cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   atan_q, atan_d;
  logic [N-1:0]   idx_q, idx_d;
  logic           last_q, last_d;
  logic           done_q, done_d;
  logic           ld;
  logic           xfer;
  logic           kill;

`ifdef CORDIC_SEQ_ABORT_EN
  assign kill = abort && (state_q != S_IDLE);
`else
  logic abort_unused;
  assign abort_unused = abort;
  assign kill         = 1'b0;
`endif

  // The output register refills whenever it is empty or being drained this edge.
  assign ld   = (state_q == S_RUN) && (!valid_q || bus.step_ready);
  assign xfer = valid_q && bus.step_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    atan_d  = atan_q;
    idx_d   = idx_q;
    last_d  = last_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (ld) begin
          atan_d  = bus.lut_data;
          idx_d   = cnt_q;
          last_d  = (cnt_q == CNT_LAST);
          valid_d = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (xfer) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        valid_d = 1'b0;
      end
    endcase
    // Cancellation overrides any load or transfer happening on the same edge.
    if (kill) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      atan_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      atan_q  <= atan_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign bus.lut_addr   = cnt_q;
  assign bus.step_valid = valid_q;
  assign bus.step_atan  = atan_q;
  assign bus.step_idx   = idx_q;
  assign bus.step_last  = last_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = done_q;

endmodule

// File: tb/tb_cordic_atan_sequencer.sv
// Bench for cordic_atan_sequencer: a vector table for the ready-high run, a stream scoreboard
// for random/backpressured runs, and hand sequences for restart, reset and abort corners.
module tb_cordic_atan_sequencer;

  localparam int ITER = 16;

  logic clk;
  logic rst_n;
  logic start;
  logic abort;
  logic busy;
  logic done;

  cordic_atan_sequencer_if #(.W(32), .N(4)) bus ();

  cordic_atan_sequencer #(.W(32), .N(4), .ITER(ITER)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  // Single-precision atan(2^-i), i = 0..15.
  logic [31:0] lut [16] = '{
    32'h3F490FDB, 32'h3EED6338, 32'h3E7ADBB0, 32'h3DFEADD5,
    32'h3D7FAADE, 32'h3CFFEAAE, 32'h3C7FFAAB, 32'h3BFFFEAB,
    32'h3B7FFFAB, 32'h3AFFFFEB, 32'h3A7FFFFB, 32'h39FFFFFF,
    32'h39800000, 32'h39000000, 32'h38800000, 32'h38000000
  };

  always_comb bus.lut_data = lut[bus.lut_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          off;
    bit          chk;
    bit          valid;
    int          idx;
    logic [31:0] atan;
    bit          last;
    bit          busy;
    bit          done;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_idx(input int idx);
    int c = 0;
    while (!(bus.step_valid && int'(bus.step_idx) == idx) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check($sformatf("wait_idx%0d_in_time", idx), 32'(c < 100), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done_in_time"}, 32'(c < 200), 32'd1);
  endtask

  // Scoreboard run: the expected stream is simply idx 0..ITER-1 carrying lut[idx], in order.
  task automatic run_stream(input string tag, input int pct, input int stall_idx,
                            input int poke_idx, input int abort_idx);
    int          n_xfer = 0;
    int          n_done = 0;
    int          stall_left = 5;
    int          cyc = 0;
    bit          p_stall = 0;
    logic [31:0] p_atan;
    logic [3:0]  p_idx;
    logic [3:0]  p_addr;
    logic        p_last;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    while (n_done == 0 && cyc < 2000) begin
      if (p_stall) begin
        check({tag, "_stall_valid"}, 32'(bus.step_valid), 32'd1);
        check({tag, "_stall_atan"}, bus.step_atan, p_atan);
        check({tag, "_stall_idx"}, 32'(bus.step_idx), 32'(p_idx));
        check({tag, "_stall_last"}, 32'(bus.step_last), 32'(p_last));
        check({tag, "_stall_addr"}, 32'(bus.lut_addr), 32'(p_addr));
      end
      if (bus.step_valid && int'(bus.step_idx) == stall_idx && stall_left > 0) begin
        bus.step_ready = 1'b0;
        stall_left--;
        check({tag, "_bp_addr"}, 32'(bus.lut_addr), 32'((stall_idx + 1) % 16));
      end else begin
        bus.step_ready = ($urandom_range(99) < pct);
      end
      start = bus.step_valid && int'(bus.step_idx) == poke_idx;
      abort = bus.step_valid && int'(bus.step_idx) == abort_idx;
      if (bus.step_valid && bus.step_ready) begin
        $display("%s: transfer %0d idx=%0d atan=0x%08h last=%0b", tag, n_xfer,
                 bus.step_idx, bus.step_atan, bus.step_last);
        check({tag, "_idx"}, 32'(bus.step_idx), 32'(n_xfer % 16));
        check({tag, "_atan"}, bus.step_atan, lut[n_xfer % 16]);
        check({tag, "_last"}, 32'(bus.step_last), 32'(n_xfer == ITER - 1));
        n_xfer++;
      end
      p_stall = bus.step_valid && !bus.step_ready;
      p_atan  = bus.step_atan;
      p_idx   = bus.step_idx;
      p_addr  = bus.lut_addr;
      p_last  = bus.step_last;
      if (done) begin
        n_done++;
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_valid_at_done"}, 32'(bus.step_valid), 32'd0);
      end else begin
        check({tag, "_busy_before_done"}, 32'(busy), 32'd1);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    abort = 1'b0;
    bus.step_ready = 1'b1;
    check({tag, "_in_time"}, 32'(cyc < 2000), 32'd1);
    check({tag, "_n_xfer"}, 32'(n_xfer), 32'(ITER));
    check({tag, "_stalls_used"}, 32'(stall_idx < 0 ? 5 : 5 - stall_left), 32'd5);
    check({tag, "_done_pulse_len"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cur;
    int n_done;
    vecs[0] = '{0,  0, 0, 0,  32'h0,        0, 1, 0};
    vecs[1] = '{1,  1, 1, 0,  32'h3F490FDB, 0, 1, 0};
    vecs[2] = '{2,  1, 1, 1,  32'h3EED6338, 0, 1, 0};
    vecs[3] = '{4,  1, 1, 3,  32'h3DFEADD5, 0, 1, 0};
    vecs[4] = '{9,  1, 1, 8,  32'h3B7FFFAB, 0, 1, 0};
    vecs[5] = '{16, 1, 1, 15, 32'h38000000, 1, 1, 0};
    vecs[6] = '{17, 0, 0, 0,  32'h0,        0, 0, 1};
    vecs[7] = '{18, 0, 0, 0,  32'h0,        0, 0, 0};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    bus.step_ready = 1'b0;
    #1;
    check("rst_valid", 32'(bus.step_valid), 32'd0);
    check("rst_atan", bus.step_atan, 32'd0);
    check("rst_idx", 32'(bus.step_idx), 32'd0);
    check("rst_last", 32'(bus.step_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(bus.lut_addr), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Ready-high run checked against the vector table, offsets counted from the start edge.
    @(negedge clk);
    start = 1'b1;
    bus.step_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cur = 0;
    for (int v = 0; v < 8; v++) begin
      while (cur < vecs[v].off) begin
        @(negedge clk);
        cur++;
      end
      $display("table: off=%0d valid=%0b idx=%0d atan=0x%08h busy=%0b done=%0b", cur,
               bus.step_valid, bus.step_idx, bus.step_atan, busy, done);
      check($sformatf("tbl%0d_valid", v), 32'(bus.step_valid), 32'(vecs[v].valid));
      check($sformatf("tbl%0d_busy", v), 32'(busy), 32'(vecs[v].busy));
      check($sformatf("tbl%0d_done", v), 32'(done), 32'(vecs[v].done));
      check($sformatf("tbl%0d_addr", v), 32'(bus.lut_addr),
            32'(vecs[v].chk ? (vecs[v].idx + 1) % 16 : 0));
      if (vecs[v].chk) begin
        check($sformatf("tbl%0d_idx", v), 32'(bus.step_idx), 32'(vecs[v].idx));
        check($sformatf("tbl%0d_atan", v), bus.step_atan, vecs[v].atan);
        check($sformatf("tbl%0d_last", v), 32'(bus.step_last), 32'(vecs[v].last));
      end
    end

    run_stream("rand50", 50, -1, -1, -1);
    run_stream("backpressure", 100, 3, -1, -1);
    run_stream("start_mid_run", 70, -1, 6, -1);
`ifndef CORDIC_SEQ_ABORT_EN
    run_stream("abort_ignored", 100, -1, -1, 9);
`endif

    // Back-to-back: start presented in the done cycle begins the next run.
    @(negedge clk);
    start = 1'b1;
    bus.step_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("b2b_first");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    $display("b2b: after restart edge busy=%0b valid=%0b", busy, bus.step_valid);
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_valid_not_yet", 32'(bus.step_valid), 32'd0);
    @(negedge clk);
    $display("b2b: next cycle valid=%0b idx=%0d", bus.step_valid, bus.step_idx);
    check("b2b_valid", 32'(bus.step_valid), 32'd1);
    check("b2b_idx0", 32'(bus.step_idx), 32'd0);
    check("b2b_atan0", bus.step_atan, lut[0]);
    wait_done("b2b_second");
    @(negedge clk);

    // Reset mid-run clears everything without waiting for a clock edge.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idx(7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("midrst: valid=%0b idx=%0d busy=%0b addr=%0d", bus.step_valid, bus.step_idx,
             busy, bus.lut_addr);
    check("midrst_valid", 32'(bus.step_valid), 32'd0);
    check("midrst_atan", bus.step_atan, 32'd0);
    check("midrst_idx", 32'(bus.step_idx), 32'd0);
    check("midrst_last", 32'(bus.step_last), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_addr", 32'(bus.lut_addr), 32'd0);
    repeat (2) @(negedge clk);
    check("midrst_hold_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    run_stream("after_reset", 100, -1, -1, -1);

`ifdef CORDIC_SEQ_ABORT_EN
    @(negedge clk);
    start = 1'b1;
    bus.step_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idx(9);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    $display("abort: valid=%0b busy=%0b addr=%0d done=%0b", bus.step_valid, busy,
             bus.lut_addr, done);
    check("abort_valid", 32'(bus.step_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(bus.lut_addr), 32'd0);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    run_stream("after_abort", 100, -1, -1, -1);
`else
    n_done = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_atan_sequencer.md
# cordic_atan_sequencer

- Reads the 32-bit single-precision arctangent table, one iteration per transfer.
- Drives the table address and captures the returned constant into an output register.
- Streams the constant, the iteration index (shift amount) and a last flag to the CORDIC Z-path datapath over a valid/ready handshake.
- Sits between the combinational atan(2^-i) ROM and the Arch3 CORDIC iteration engine.

## Interface
- `W`, 32: data width of the table constant (IEEE-754 single).
- `N`, 4: table address width.
- `ITER`, 16: iterations per run; legal range 1..2^N.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `abort`  in  1  cancel a run (see Configuration).
- `lut_addr`  out  N  address to the table; combinational from the internal counter `cnt`.
- `lut_data`  in  W  table output; combinational function of `lut_addr`.
- `step_valid`  out  1  output register holds a valid step.
- `step_ready`  in  1  consumer accepts the step this cycle.
- `step_atan`  out  W  captured table constant.
- `step_idx`  out  N  iteration index of the captured constant.
- `step_last`  out  1  high when `step_idx == ITER-1`.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  one-cycle pulse at the end of a completed run.

## Operation
- States:
  - IDLE: `cnt = 0`.
  - RUN: issuing addresses.
  - DRAIN: all constants captured; waiting for the final handshake.
- IDLE + `start`: go to RUN at the next edge, `cnt = 0`. `start` in any other state is ignored.
- Load condition `ld = (state == RUN) && (!step_valid || step_ready)`. On `ld`:
  - `step_atan <= lut_data`, `step_idx <= cnt`, `step_last <= (cnt == ITER-1)`, `step_valid <= 1`.
  - If `cnt == ITER-1`: go to DRAIN, `cnt <= 0`. Otherwise `cnt <= cnt+1`.
- Transfer: `step_valid && step_ready` at a rising edge.
- Stall (`step_valid && !step_ready`): `step_atan`, `step_idx`, `step_last` and `lut_addr` stay stable.
- DRAIN + transfer: `step_valid <= 0`, `done <= 1` for one cycle, go to IDLE.
- `step_valid` never drops without a transfer, except on abort or reset.
- Counter arithmetic is unsigned N-bit. `cnt` never exceeds ITER-1, so there is no wrap, including ITER = 2^N.
- ITER = 1: one step with `step_last = 1`, then DRAIN.
- `busy = (state != IDLE)`, combinational from state.
- `lut_addr = cnt`; it is 0 in IDLE.

## Timing
- Reset values: `step_valid = 0`, `step_atan = 0`, `step_idx = 0`, `step_last = 0`, `done = 0`, `busy = 0`, `lut_addr = 0`, state IDLE.
- `start` sampled at edge k:
  - `busy` high after edge k.
  - First `step_valid` high after edge k+1.
- Throughput: one step per cycle with `step_ready` held high.
- A full run with ready always high:
  - `step_valid` is high for ITER cycles.
  - `done` pulses in the cycle after the last transfer, i.e. after edge k+ITER+1.
  - `busy` falls in the same cycle as `done`.
- A new `start` is accepted in the same cycle `done` is high, because the state is already IDLE.
- Reset mid-run: all registers return to reset values immediately, asynchronously. No `done` pulse.

## Configuration
- Macro `CORDIC_SEQ_ABORT_EN`.
- Defined:
  - `abort = 1` in RUN or DRAIN forces IDLE at the next edge: `step_valid <= 0`, `cnt <= 0`, no `done`.
  - Abort has priority over a simultaneous transfer or load.
  - `abort` in IDLE is ignored; a simultaneous `start` in IDLE is accepted.
- Undefined: the `abort` port exists but is ignored. The abort logic is not synthesized.

## Test plan
- **Full run, ready high, bench LUT with atan constants, ITER = 16, `start` at edge 0:**
  - Edge 2: `step_idx = 0`, `step_atan = 0x3F490FDB`.
  - Edge 17: `step_idx = 15`, `step_atan = 0x38000000`, `step_last = 1`.
  - `done` pulses once after edge 18.
- **Backpressure:** drop `step_ready` while `step_idx = 3` (`0x3DFEADD5`) is presented.
  - Outputs and `lut_addr = 4` hold for 5 cycles.
  - Indices continue 4, 5, … with no skip or duplicate.
- **Random `step_ready` (50%), ITER = 16:**
  - Exactly 16 transfers, indices 0..15 in order.
  - One `done`; `busy` low only after it.
- **`start` while busy is ignored; back-to-back runs:**
  - `start` pulsed mid-run has no effect.
  - `start` in the `done` cycle begins the second run, whose first valid appears 2 cycles later.
- **Reset mid-run:** `rst_n` low during step 7 clears all outputs asynchronously. The next run restarts at `step_idx = 0`.
- **`CORDIC_SEQ_ABORT_EN` defined:** `abort` with `step_valid = 1` and `step_ready = 1` at step 9.
  - `step_valid = 0` next cycle.
  - No `done`.
  - `lut_addr = 0`.
